// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial double-dabble binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   // Bit counter must index 0..IN_W-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/dd_digit_adjust.sv
// One BCD digit of the double-dabble pre-shift correction: add 3 when the digit is 5 or more.
module dd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= BCD_ADJ_THRESH) begin
         digit_o = digit_i + BCD_ADJ_ADD;
      end
   end

endmodule

// File: rtl/bcd_serial_converter.sv
// Handshaked binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Results and the overflow flag are registered and held until the next conversion completes.
module bcd_serial_converter
   import bcd_pkg::*;
#(
   parameter int unsigned IN_W   = 5,
   parameter int unsigned DIGITS = 2
) (
   input  logic                CLOCK_50,
   input  logic                RESETN,
   input  logic [IN_W-1:0]     bin_in,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                overflow
);

   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned CntW = cnt_width(IN_W);
   localparam logic [CntW-1:0] LastCnt = CntW'(IN_W - 1);

   state_e          state_q, state_d;
   logic [IN_W-1:0] shreg_q, shreg_d;
   logic [BcdW-1:0] scratch_q, scratch_d;
   logic [BcdW-1:0] scratch_adj;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            ovf_scratch_q, ovf_scratch_d;
   logic [BcdW-1:0] bcd_q, bcd_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;

   for (genvar g = 0; g < DIGITS; g++) begin : gen_adj
      dd_digit_adjust u_adj (
         .digit_i (scratch_q[4*g +: 4]),
         .digit_o (scratch_adj[4*g +: 4])
      );
   end

   always_comb begin
      state_d       = state_q;
      shreg_d       = shreg_q;
      scratch_d     = scratch_q;
      cnt_d         = cnt_q;
      ovf_scratch_d = ovf_scratch_q;
      bcd_d         = bcd_q;
      ovf_d         = ovf_q;
      done_d        = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               shreg_d       = bin_in;
               scratch_d     = '0;
               cnt_d         = '0;
               ovf_scratch_d = 1'b0;
               state_d       = StShift;
            end
         end

         StShift: begin
            // Bit leaving the top digit would belong to a dropped higher digit.
            scratch_d     = {scratch_adj[BcdW-2:0], shreg_q[IN_W-1]};
            shreg_d       = {shreg_q[IN_W-2:0], 1'b0};
            ovf_scratch_d = ovf_scratch_q | scratch_adj[BcdW-1];
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end
         end

         StDone: begin
            bcd_d   = scratch_q;
            ovf_d   = ovf_scratch_q;
            done_d  = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge RESETN) begin
      if (!RESETN) begin
         state_q       <= StIdle;
         shreg_q       <= '0;
         scratch_q     <= '0;
         cnt_q         <= '0;
         ovf_scratch_q <= 1'b0;
         bcd_q         <= '0;
         ovf_q         <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         scratch_q     <= scratch_d;
         cnt_q         <= cnt_d;
         ovf_scratch_q <= ovf_scratch_d;
         bcd_q         <= bcd_d;
         ovf_q         <= ovf_d;
         done_q        <= done_d;
      end
   end

   // The done cycle is still part of the conversion window for busy.
   assign busy     = (state_q != StIdle) || done_q;
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_q;

endmodule
